// File: rtl/csr_file_pkg.sv
// Shared CSR address map, write masks and write-port arbitration helper
// for the machine/debug CSR file.
package csr_file_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_DCSR      = 12'h7B0;
  localparam logic [11:0] CSR_DPC       = 12'h7B1;
  localparam logic [11:0] CSR_DSCRATCH0 = 12'h7B2;

  localparam logic [31:0] MSTATUS_WMASK   = 32'h0000_0088;
  localparam logic [31:0] MSTATUS_FIXED   = 32'h0000_1800;
  localparam logic [31:0] MIE_WMASK       = 32'h0000_0888;
  localparam logic [31:0] DCSR_EX_WMASK   = 32'h0000_8404;
  localparam logic [31:0] DCSR_EXCP_WMASK = 32'h0000_85C4;
  localparam logic [31:0] DCSR_FIXED      = 32'h4000_0003;
  localparam logic [31:0] ALIGN4_MASK     = 32'hFFFF_FFFC;

  localparam int unsigned DCSR_STOPCOUNT = 10;

  typedef struct packed {
    logic        we;
    logic [31:0] data;
  } csr_wr_t;

  // Per-address write selection: the exception port wins an address collision.
  function automatic csr_wr_t csr_pick(
    input logic [11:0] addr,
    input logic        ex_we,
    input logic [11:0] ex_addr,
    input logic [31:0] ex_data,
    input logic        excp_we,
    input logic [11:0] excp_addr,
    input logic [31:0] excp_data
  );
    csr_wr_t r;
    r.we   = 1'b0;
    r.data = '0;
    if (excp_we && (excp_addr == addr)) begin
      r.we   = 1'b1;
      r.data = excp_data;
    end else if (ex_we && (ex_addr == addr)) begin
      r.we   = 1'b1;
      r.data = ex_data;
    end
    return r;
  endfunction

endpackage

// File: rtl/csr_file_counter64.sv
// 64-bit free-running counter with independently writable 32-bit halves.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_inc,
  input  logic        i_we_lo,
  input  logic        i_we_hi,
  input  logic [63:0] i_wdata,
  output logic [63:0] o_value
);

  logic [63:0] r_value;

  // Any half-write suppresses the increment for the whole counter that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
    end else if (i_we_lo || i_we_hi) begin
      if (i_we_lo) r_value[31:0]  <= i_wdata[31:0];
      if (i_we_hi) r_value[63:32] <= i_wdata[63:32];
    end else if (i_inc) begin
      r_value <= r_value + 64'd1;
    end
  end

  assign o_value = r_value;

endmodule

// File: rtl/csr_file.sv
// Machine/debug CSR file: dual write ports (execute, exception unit),
// combinational execute read port, mcycle/minstret counters.
module csr_file
  import csr_file_pkg::*;
#(
  parameter logic [31:0] HART_ID  = 32'd0,
  parameter logic [31:0] MISA_VAL = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_we_i,
  input  logic [31:0] ex_waddr_i,
  input  logic [31:0] ex_wdata_i,
  input  logic [31:0] ex_raddr_i,
  output logic [31:0] ex_rdata_o,
  input  logic        excp_we_i,
  input  logic [31:0] excp_waddr_i,
  input  logic [31:0] excp_wdata_i,
  input  logic        inst_retired_i,
  input  logic        debug_mode_i,
  input  logic        irq_software_i,
  input  logic        irq_timer_i,
  input  logic        irq_external_i,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mstatus_o,
  output logic [31:0] mie_o,
  output logic [31:0] dpc_o,
  output logic [31:0] dcsr_o
);

  logic [11:0] w_ex_addr;
  logic [11:0] w_excp_addr;
  logic        w_unused;

  assign w_ex_addr   = ex_waddr_i[11:0];
  assign w_excp_addr = excp_waddr_i[11:0];
  assign w_unused    = ^{ex_waddr_i[31:12], ex_raddr_i[31:12], excp_waddr_i[31:12]};

  csr_wr_t w_wr_mstatus, w_wr_mie, w_wr_mtvec, w_wr_mscratch, w_wr_mepc, w_wr_mcause;
  csr_wr_t w_wr_dcsr, w_wr_dpc, w_wr_dscratch0;
  csr_wr_t w_wr_mcycle, w_wr_mcycleh, w_wr_minstret, w_wr_minstreth;

  assign w_wr_mstatus   = csr_pick(CSR_MSTATUS,   ex_we_i, w_ex_addr, ex_wdata_i, excp_we_i, w_excp_addr, excp_wdata_i);
  assign w_wr_mie       = csr_pick(CSR_MIE,       ex_we_i, w_ex_addr, ex_wdata_i, excp_we_i, w_excp_addr, excp_wdata_i);
  assign w_wr_mtvec     = csr_pick(CSR_MTVEC,     ex_we_i, w_ex_addr, ex_wdata_i, excp_we_i, w_excp_addr, excp_wdata_i);
  assign w_wr_mscratch  = csr_pick(CSR_MSCRATCH,  ex_we_i, w_ex_addr, ex_wdata_i, excp_we_i, w_excp_addr, excp_wdata_i);
  assign w_wr_mepc      = csr_pick(CSR_MEPC,      ex_we_i, w_ex_addr, ex_wdata_i, excp_we_i, w_excp_addr, excp_wdata_i);
  assign w_wr_mcause    = csr_pick(CSR_MCAUSE,    ex_we_i, w_ex_addr, ex_wdata_i, excp_we_i, w_excp_addr, excp_wdata_i);
  assign w_wr_dcsr      = csr_pick(CSR_DCSR,      ex_we_i, w_ex_addr, ex_wdata_i, excp_we_i, w_excp_addr, excp_wdata_i);
  assign w_wr_dpc       = csr_pick(CSR_DPC,       ex_we_i, w_ex_addr, ex_wdata_i, excp_we_i, w_excp_addr, excp_wdata_i);
  assign w_wr_dscratch0 = csr_pick(CSR_DSCRATCH0, ex_we_i, w_ex_addr, ex_wdata_i, excp_we_i, w_excp_addr, excp_wdata_i);
  assign w_wr_mcycle    = csr_pick(CSR_MCYCLE,    ex_we_i, w_ex_addr, ex_wdata_i, excp_we_i, w_excp_addr, excp_wdata_i);
  assign w_wr_mcycleh   = csr_pick(CSR_MCYCLEH,   ex_we_i, w_ex_addr, ex_wdata_i, excp_we_i, w_excp_addr, excp_wdata_i);
  assign w_wr_minstret  = csr_pick(CSR_MINSTRET,  ex_we_i, w_ex_addr, ex_wdata_i, excp_we_i, w_excp_addr, excp_wdata_i);
  assign w_wr_minstreth = csr_pick(CSR_MINSTRETH, ex_we_i, w_ex_addr, ex_wdata_i, excp_we_i, w_excp_addr, excp_wdata_i);

  // dcsr write mask depends on which port won the address.
  logic [31:0] w_dcsr_wmask;
  assign w_dcsr_wmask = (excp_we_i && (w_excp_addr == CSR_DCSR)) ? DCSR_EXCP_WMASK : DCSR_EX_WMASK;

  logic [31:0] r_mstatus, r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause;
  logic [31:0] r_dcsr, r_dpc, r_dscratch0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mstatus   <= MSTATUS_FIXED;
      r_mie       <= '0;
      r_mtvec     <= '0;
      r_mscratch  <= '0;
      r_mepc      <= '0;
      r_mcause    <= '0;
      r_dcsr      <= DCSR_FIXED;
      r_dpc       <= '0;
      r_dscratch0 <= '0;
    end else begin
      if (w_wr_mstatus.we)   r_mstatus   <= MSTATUS_FIXED | (w_wr_mstatus.data & MSTATUS_WMASK);
      if (w_wr_mie.we)       r_mie       <= w_wr_mie.data & MIE_WMASK;
      if (w_wr_mtvec.we)     r_mtvec     <= w_wr_mtvec.data & ALIGN4_MASK;
      if (w_wr_mscratch.we)  r_mscratch  <= w_wr_mscratch.data;
      if (w_wr_mepc.we)      r_mepc      <= w_wr_mepc.data & ALIGN4_MASK;
      if (w_wr_mcause.we)    r_mcause    <= w_wr_mcause.data;
      if (w_wr_dcsr.we)      r_dcsr      <= (r_dcsr & ~w_dcsr_wmask) | (w_wr_dcsr.data & w_dcsr_wmask);
      if (w_wr_dpc.we)       r_dpc       <= w_wr_dpc.data & ALIGN4_MASK;
      if (w_wr_dscratch0.we) r_dscratch0 <= w_wr_dscratch0.data;
    end
  end

  logic        w_count_en;
  logic [63:0] w_mcycle, w_minstret;

  assign w_count_en = !(debug_mode_i && r_dcsr[DCSR_STOPCOUNT]);

  csr_counter64 u_mcycle (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_count_en),
    .i_we_lo (w_wr_mcycle.we),
    .i_we_hi (w_wr_mcycleh.we),
    .i_wdata ({w_wr_mcycleh.data, w_wr_mcycle.data}),
    .o_value (w_mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_count_en && inst_retired_i),
    .i_we_lo (w_wr_minstret.we),
    .i_we_hi (w_wr_minstreth.we),
    .i_wdata ({w_wr_minstreth.data, w_wr_minstret.data}),
    .o_value (w_minstret)
  );

  logic [31:0] w_mip;
  assign w_mip = {20'd0, irq_external_i, 3'd0, irq_timer_i, 3'd0, irq_software_i, 3'd0};

  logic [31:0] w_rdata;
  always_comb begin
    w_rdata = '0;
    case (ex_raddr_i[11:0])
      CSR_MSTATUS:                 w_rdata = r_mstatus;
      CSR_MISA:                    w_rdata = MISA_VAL;
      CSR_MIE:                     w_rdata = r_mie;
      CSR_MTVEC:                   w_rdata = r_mtvec;
      CSR_MSCRATCH:                w_rdata = r_mscratch;
      CSR_MEPC:                    w_rdata = r_mepc;
      CSR_MCAUSE:                  w_rdata = r_mcause;
      CSR_MIP:                     w_rdata = w_mip;
      CSR_MCYCLE,   CSR_CYCLE:     w_rdata = w_mcycle[31:0];
      CSR_MCYCLEH,  CSR_CYCLEH:    w_rdata = w_mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:   w_rdata = w_minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: w_rdata = w_minstret[63:32];
      CSR_MHARTID:                 w_rdata = HART_ID;
      CSR_DCSR:                    w_rdata = r_dcsr;
      CSR_DPC:                     w_rdata = r_dpc;
      CSR_DSCRATCH0:               w_rdata = r_dscratch0;
      default:                     w_rdata = '0;
    endcase
  end

  assign ex_rdata_o = w_rdata;
  assign mtvec_o    = r_mtvec;
  assign mepc_o     = r_mepc;
  assign mstatus_o  = r_mstatus;
  assign mie_o      = r_mie;
  assign dpc_o      = r_dpc;
  assign dcsr_o     = r_dcsr;

endmodule

// File: tb/tb_csr_file.sv
// Randomised and directed self-checking bench for csr_file against a
// register-level reference model.
module tb_csr_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_we_i, excp_we_i, inst_retired_i, debug_mode_i;
  logic        irq_software_i, irq_timer_i, irq_external_i;
  logic [31:0] ex_waddr_i, ex_wdata_i, ex_raddr_i, excp_waddr_i, excp_wdata_i;
  logic [31:0] ex_rdata_o, mtvec_o, mepc_o, mstatus_o, mie_o, dpc_o, dcsr_o;

  always #5 clk = ~clk;

  csr_file #(.HART_ID(32'd0), .MISA_VAL(32'h4000_0100)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
    .ex_raddr_i(ex_raddr_i), .ex_rdata_o(ex_rdata_o),
    .excp_we_i(excp_we_i), .excp_waddr_i(excp_waddr_i), .excp_wdata_i(excp_wdata_i),
    .inst_retired_i(inst_retired_i), .debug_mode_i(debug_mode_i),
    .irq_software_i(irq_software_i), .irq_timer_i(irq_timer_i), .irq_external_i(irq_external_i),
    .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mstatus_o(mstatus_o), .mie_o(mie_o),
    .dpc_o(dpc_o), .dcsr_o(dcsr_o)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [31:0] m_dcsr, m_dpc, m_dscratch0;
  logic [63:0] m_mcycle, m_minstret;
  bit          m_cyc_written, m_ins_written;

  logic [11:0] k_addrs [0:24] = '{
    12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
    12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82,
    12'hF14, 12'h7B0, 12'h7B1, 12'h7B2, 12'h123, 12'h343, 12'h7B3, 12'hFFF, 12'h306};

  function void model_reset();
    m_mstatus = 32'h0000_1800; m_dcsr = 32'h4000_0003;
    m_mie = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
    m_dpc = 0; m_dscratch0 = 0; m_mcycle = 0; m_minstret = 0;
  endfunction

  function logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h301: return 32'h4000_0100;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return (irq_software_i ? 32'h8 : 32'h0) | (irq_timer_i ? 32'h80 : 32'h0)
                    | (irq_external_i ? 32'h800 : 32'h0);
      12'hB00, 12'hC00: return m_mcycle[31:0];
      12'hB80, 12'hC80: return m_mcycle[63:32];
      12'hB02, 12'hC02: return m_minstret[31:0];
      12'hB82, 12'hC82: return m_minstret[63:32];
      12'hF14: return 32'd0;
      12'h7B0: return m_dcsr;
      12'h7B1: return m_dpc;
      12'h7B2: return m_dscratch0;
      default: return 32'd0;
    endcase
  endfunction

  function void model_write(input logic [11:0] a, input logic [31:0] d, input bit from_excp);
    logic [31:0] wm;
    case (a)
      12'h300: m_mstatus = 32'h1800 | (d & 32'h88);
      12'h304: m_mie = d & 32'h888;
      12'h305: m_mtvec = {d[31:2], 2'b00};
      12'h340: m_mscratch = d;
      12'h341: m_mepc = {d[31:2], 2'b00};
      12'h342: m_mcause = d;
      12'h7B0: begin
        wm = from_excp ? 32'h0000_85C4 : 32'h0000_8404;
        m_dcsr = (m_dcsr & ~wm) | (d & wm);
      end
      12'h7B1: m_dpc = {d[31:2], 2'b00};
      12'h7B2: m_dscratch0 = d;
      12'hB00: begin m_mcycle[31:0] = d; m_cyc_written = 1; end
      12'hB80: begin m_mcycle[63:32] = d; m_cyc_written = 1; end
      12'hB02: begin m_minstret[31:0] = d; m_ins_written = 1; end
      12'hB82: begin m_minstret[63:32] = d; m_ins_written = 1; end
      default: ;
    endcase
  endfunction

  // Advance one clock, updating the model with the inputs present at the edge.
  task automatic tick();
    bit frozen;
    if (rst_n) begin
      frozen = debug_mode_i && m_dcsr[10];
      m_cyc_written = 0; m_ins_written = 0;
      if (ex_we_i && !(excp_we_i && ex_waddr_i[11:0] == excp_waddr_i[11:0]))
        model_write(ex_waddr_i[11:0], ex_wdata_i, 0);
      if (excp_we_i) model_write(excp_waddr_i[11:0], excp_wdata_i, 1);
      if (!m_cyc_written && !frozen) m_mcycle = m_mcycle + 64'd1;
      if (!m_ins_written && !frozen && inst_retired_i) m_minstret = m_minstret + 64'd1;
    end
    @(posedge clk);
    #1;
    ex_we_i = 0;
    excp_we_i = 0;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    rst_n = 0; ex_we_i = 0; excp_we_i = 0; inst_retired_i = 0; debug_mode_i = 0;
    irq_software_i = 0; irq_timer_i = 0; irq_external_i = 0;
    ex_waddr_i = 0; ex_wdata_i = 0; excp_waddr_i = 0; excp_wdata_i = 0;
    ex_raddr_i = 32'h300;
    model_reset();
    #12;
    n_cmp++; if (ex_rdata_o !== 32'h0000_1800) begin n_fail++; $display("FAIL read_in_reset: got %h want %h", ex_rdata_o, 32'h0000_1800); end
    tick(); tick();
    rst_n = 1;
    ex_raddr_i = 32'h300; #1;
    n_cmp++; if (ex_rdata_o !== 32'h0000_1800) begin n_fail++; $display("FAIL rst_mstatus: got %h want %h", ex_rdata_o, 32'h0000_1800); end
    ex_raddr_i = 32'h7B0; #1;
    n_cmp++; if (ex_rdata_o !== 32'h4000_0003) begin n_fail++; $display("FAIL rst_dcsr: got %h want %h", ex_rdata_o, 32'h4000_0003); end
    ex_raddr_i = 32'h301; #1;
    n_cmp++; if (ex_rdata_o !== 32'h4000_0100) begin n_fail++; $display("FAIL rst_misa: got %h want %h", ex_rdata_o, 32'h4000_0100); end
    ex_raddr_i = 32'hB00; #1;
    n_cmp++; if (ex_rdata_o !== 32'd0) begin n_fail++; $display("FAIL rst_mcycle: got %h want %h", ex_rdata_o, 32'd0); end
    exp = m_mtvec | m_mepc | m_mie | m_dpc;
    n_cmp++; if ((mtvec_o | mepc_o | mie_o | dpc_o) !== exp) begin n_fail++; $display("FAIL rst_outputs: got %h want %h", mtvec_o | mepc_o | mie_o | dpc_o, exp); end
  endtask

  task automatic test_masks();
    logic [31:0] old;
    ex_we_i = 1; ex_waddr_i = 32'h300; ex_wdata_i = 32'hFFFF_FFFF; tick();
    n_cmp++; if (mstatus_o !== 32'h0000_1888) begin n_fail++; $display("FAIL mstatus_mask: got %h want %h", mstatus_o, 32'h0000_1888); end
    ex_we_i = 1; ex_waddr_i = 32'h305; ex_wdata_i = 32'hFFFF_FFFF; tick();
    n_cmp++; if (mtvec_o !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL mtvec_align: got %h want %h", mtvec_o, 32'hFFFF_FFFC); end
    ex_we_i = 1; ex_waddr_i = 32'h304; ex_wdata_i = 32'hFFFF_FFFF; tick();
    n_cmp++; if (mie_o !== 32'h0000_0888) begin n_fail++; $display("FAIL mie_mask: got %h want %h", mie_o, 32'h0000_0888); end
    ex_we_i = 1; ex_waddr_i = 32'h341; ex_wdata_i = 32'h0000_1233; tick();
    n_cmp++; if (mepc_o !== 32'h0000_1230) begin n_fail++; $display("FAIL mepc_align: got %h want %h", mepc_o, 32'h0000_1230); end
    // same-cycle read sees the old value
    old = m_mscratch;
    ex_we_i = 1; ex_waddr_i = 32'h340; ex_wdata_i = 32'hDEAD_BEEF; ex_raddr_i = 32'h340; #1;
    n_cmp++; if (ex_rdata_o !== old) begin n_fail++; $display("FAIL no_bypass: got %h want %h", ex_rdata_o, old); end
    tick();
    n_cmp++; if (ex_rdata_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL mscratch_wr: got %h want %h", ex_rdata_o, 32'hDEAD_BEEF); end
  endtask

  task automatic test_dual_write();
    excp_we_i = 1; excp_waddr_i = 32'h342; excp_wdata_i = 32'h8000_000B;
    ex_we_i = 1; ex_waddr_i = 32'h342; ex_wdata_i = 32'h5; tick();
    ex_raddr_i = 32'h342; #1;
    n_cmp++; if (ex_rdata_o !== 32'h8000_000B) begin n_fail++; $display("FAIL collide_excp_wins: got %h want %h", ex_rdata_o, 32'h8000_000B); end
    excp_we_i = 1; excp_waddr_i = 32'h342; excp_wdata_i = 32'h0000_0007;
    ex_we_i = 1; ex_waddr_i = 32'h340; ex_wdata_i = 32'h1357_9BDF; tick();
    ex_raddr_i = 32'h342; #1;
    n_cmp++; if (ex_rdata_o !== 32'h0000_0007) begin n_fail++; $display("FAIL dual_mcause: got %h want %h", ex_rdata_o, 32'h0000_0007); end
    ex_raddr_i = 32'h340; #1;
    n_cmp++; if (ex_rdata_o !== 32'h1357_9BDF) begin n_fail++; $display("FAIL dual_mscratch: got %h want %h", ex_rdata_o, 32'h1357_9BDF); end
  endtask

  task automatic test_counter();
    logic [31:0] snap_c, snap_i;
    ex_we_i = 1; ex_waddr_i = 32'hB00; ex_wdata_i = 32'hFFFF_FFFF;
    excp_we_i = 1; excp_waddr_i = 32'hB80; excp_wdata_i = 32'h0;
    tick(); tick(); tick();
    ex_raddr_i = 32'hB00; #1;
    n_cmp++; if (ex_rdata_o !== 32'h1) begin n_fail++; $display("FAIL mcycle_wrap_lo: got %h want %h", ex_rdata_o, 32'h1); end
    ex_raddr_i = 32'hC80; #1;
    n_cmp++; if (ex_rdata_o !== 32'h1) begin n_fail++; $display("FAIL mcycle_wrap_hi: got %h want %h", ex_rdata_o, 32'h1); end
    ex_we_i = 1; ex_waddr_i = 32'h7B0; ex_wdata_i = 32'h0000_0400; tick();
    debug_mode_i = 1; inst_retired_i = 1;
    snap_c = m_mcycle[31:0]; snap_i = m_minstret[31:0];
    tick(); tick(); tick();
    ex_raddr_i = 32'hB00; #1;
    n_cmp++; if (ex_rdata_o !== snap_c) begin n_fail++; $display("FAIL mcycle_frozen: got %h want %h", ex_rdata_o, snap_c); end
    ex_raddr_i = 32'hC02; #1;
    n_cmp++; if (ex_rdata_o !== snap_i) begin n_fail++; $display("FAIL minstret_frozen: got %h want %h", ex_rdata_o, snap_i); end
    debug_mode_i = 0; tick(); tick();
    inst_retired_i = 0;
    ex_raddr_i = 32'hB02; #1;
    n_cmp++; if (ex_rdata_o !== snap_i + 32'd2) begin n_fail++; $display("FAIL minstret_resume: got %h want %h", ex_rdata_o, snap_i + 32'd2); end
    ex_raddr_i = 32'hB00; #1;
    n_cmp++; if (ex_rdata_o !== m_mcycle[31:0]) begin n_fail++; $display("FAIL mcycle_resume: got %h want %h", ex_rdata_o, m_mcycle[31:0]); end
  endtask

  task automatic test_mip();
    irq_timer_i = 1; ex_raddr_i = 32'h344; #1;
    n_cmp++; if (ex_rdata_o !== 32'h80) begin n_fail++; $display("FAIL mip_timer: got %h want %h", ex_rdata_o, 32'h80); end
    ex_we_i = 1; ex_waddr_i = 32'h344; ex_wdata_i = 32'hFFFF_FFFF; tick();
    n_cmp++; if (ex_rdata_o !== 32'h80) begin n_fail++; $display("FAIL mip_ro: got %h want %h", ex_rdata_o, 32'h80); end
    irq_software_i = 1; irq_external_i = 1; #1;
    n_cmp++; if (ex_rdata_o !== 32'h888) begin n_fail++; $display("FAIL mip_all: got %h want %h", ex_rdata_o, 32'h888); end
    irq_software_i = 0; irq_timer_i = 0; irq_external_i = 0;
    excp_we_i = 1; excp_waddr_i = 32'h301; excp_wdata_i = 32'h0; tick();
    ex_raddr_i = 32'h301; #1;
    n_cmp++; if (ex_rdata_o !== 32'h4000_0100) begin n_fail++; $display("FAIL misa_ro: got %h want %h", ex_rdata_o, 32'h4000_0100); end
  endtask

  task automatic test_dcsr();
    ex_we_i = 1; ex_waddr_i = 32'h7B0; ex_wdata_i = 32'hFFFF_FFFF; tick();
    n_cmp++; if (dcsr_o !== 32'h4000_8407) begin n_fail++; $display("FAIL dcsr_ex: got %h want %h", dcsr_o, 32'h4000_8407); end
    excp_we_i = 1; excp_waddr_i = 32'h7B0; excp_wdata_i = 32'h0000_00C0; tick();
    n_cmp++; if (dcsr_o[8:6] !== 3'd3) begin n_fail++; $display("FAIL dcsr_cause: got %h want %h", dcsr_o[8:6], 3'd3); end
    n_cmp++; if (dcsr_o !== m_dcsr) begin n_fail++; $display("FAIL dcsr_excp_full: got %h want %h", dcsr_o, m_dcsr); end
    ex_we_i = 1; ex_waddr_i = 32'h7B1; ex_wdata_i = 32'h8000_0007; tick();
    n_cmp++; if (dpc_o !== 32'h8000_0004) begin n_fail++; $display("FAIL dpc_align: got %h want %h", dpc_o, 32'h8000_0004); end
  endtask

  task automatic test_random(input int unsigned n);
    logic [31:0] act [0:5];
    logic [31:0] exp [0:5];
    logic [31:0] r;
    logic [11:0] ra;
    for (int unsigned i = 0; i < n; i++) begin
      ex_we_i        = ($urandom_range(0, 2) != 0);
      ex_waddr_i     = {20'd0, k_addrs[$urandom_range(0, 24)]};
      ex_wdata_i     = $urandom();
      excp_we_i      = ($urandom_range(0, 2) == 0);
      excp_waddr_i   = ($urandom_range(0, 3) == 0) ? ex_waddr_i : {20'd0, k_addrs[$urandom_range(0, 24)]};
      excp_wdata_i   = $urandom();
      inst_retired_i = $urandom_range(0, 1);
      debug_mode_i   = ($urandom_range(0, 7) == 0);
      irq_software_i = $urandom_range(0, 1);
      irq_timer_i    = $urandom_range(0, 1);
      irq_external_i = $urandom_range(0, 1);
      ra = k_addrs[$urandom_range(0, 24)];
      r = $urandom();
      ex_raddr_i = {r[31:12], ra};
      #1;
      n_cmp++; if (ex_rdata_o !== model_read(ra)) begin n_fail++; $display("FAIL rnd_read[%h]: got %h want %h", ra, ex_rdata_o, model_read(ra)); end
      tick();
      act = '{mtvec_o, mepc_o, mstatus_o, mie_o, dpc_o, dcsr_o};
      exp = '{m_mtvec, m_mepc, m_mstatus, m_mie, m_dpc, m_dcsr};
      for (int k = 0; k < 6; k++) begin
        n_cmp++; if (act[k] !== exp[k]) begin n_fail++; $display("FAIL rnd_out%0d: got %h want %h", k, act[k], exp[k]); end
      end
    end
    debug_mode_i = 0; inst_retired_i = 0;
    irq_software_i = 0; irq_timer_i = 0; irq_external_i = 0;
  endtask

  task automatic test_reset_mid();
    test_random(20);
    #2;
    rst_n = 0;
    model_reset();
    ex_raddr_i = 32'hB00; #1;
    n_cmp++; if (ex_rdata_o !== 32'd0) begin n_fail++; $display("FAIL mid_rst_mcycle: got %h want %h", ex_rdata_o, 32'd0); end
    n_cmp++; if (mstatus_o !== 32'h0000_1800) begin n_fail++; $display("FAIL mid_rst_mstatus: got %h want %h", mstatus_o, 32'h0000_1800); end
    n_cmp++; if (dcsr_o !== 32'h4000_0003) begin n_fail++; $display("FAIL mid_rst_dcsr: got %h want %h", dcsr_o, 32'h4000_0003); end
    tick(); tick();
    rst_n = 1;
    ex_we_i = 1; ex_waddr_i = 32'h340; ex_wdata_i = 32'h1234_5678; tick();
    ex_raddr_i = 32'h340; #1;
    n_cmp++; if (ex_rdata_o !== 32'h1234_5678) begin n_fail++; $display("FAIL post_rst_write: got %h want %h", ex_rdata_o, 32'h1234_5678); end
    ex_raddr_i = 32'hB00; #1;
    n_cmp++; if (ex_rdata_o !== m_mcycle[31:0]) begin n_fail++; $display("FAIL post_rst_mcycle: got %h want %h", ex_rdata_o, m_mcycle[31:0]); end
  endtask

  initial begin
    test_reset();
    test_masks();
    test_dual_write();
    test_counter();
    test_mip();
    test_dcsr();
    test_random(400);
    test_reset_mid();
    test_random(200);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_file.md
# csr_file

Machine- and debug-mode CSR register file for the core. It sits directly downstream of the exception/interrupt unit, whose CSR write port it consumes. It also serves the execute stage's CSR read/write port. It drives the live mtvec/mepc/mstatus/mie/dpc/dcsr values back to the exception unit and owns the 64-bit mcycle/minstret counters.

## Interface
Parameters:
- HART_ID, 0, value returned by mhartid
- MISA_VAL, 32'h4000_0100, value returned by misa (RV32I)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- ex_we_i  in  1  execute-stage CSR write enable
- ex_waddr_i  in  32  execute write address (bits [11:0] used)
- ex_wdata_i  in  32  execute write data
- ex_raddr_i  in  32  execute read address (bits [11:0] used)
- ex_rdata_o  out  32  combinational read data
- excp_we_i  in  1  exception-unit write enable
- excp_waddr_i  in  32  exception-unit write address
- excp_wdata_i  in  32  exception-unit write data
- inst_retired_i  in  1  one instruction retired this cycle
- debug_mode_i  in  1  core is in debug mode
- irq_software_i / irq_timer_i / irq_external_i  in  1 each  raw interrupt lines, reflected in mip
- mtvec_o, mepc_o, mstatus_o, mie_o, dpc_o, dcsr_o  out  32 each  current register values

## Operation
- Implemented addresses:
  - mstatus 0x300
  - misa 0x301 (RO)
  - mie 0x304
  - mtvec 0x305
  - mscratch 0x340
  - mepc 0x341
  - mcause 0x342
  - mip 0x344 (RO)
  - mcycle/mcycleh 0xB00/0xB80
  - minstret/minstreth 0xB02/0xB82
  - cycle/cycleh 0xC00/0xC80 (RO)
  - instret/instreth 0xC02/0xC82 (RO)
  - mhartid 0xF14 (RO)
  - dcsr 0x7B0
  - dpc 0x7B1
  - dscratch0 0x7B2
- Unimplemented address: read returns 0, write ignored.
- Writes to RO addresses are ignored.
- Write masks:
  - mstatus: only MIE[3] and MPIE[7] writable; MPP[12:11] hard 2'b11; all other bits read 0.
  - mie: only bits 3, 7, 11 writable.
  - mtvec, mepc, dpc: bits [1:0] read 0.
  - mip: bit 3 = irq_software_i, bit 7 = irq_timer_i, bit 11 = irq_external_i; all other bits 0.
- dcsr field ownership:
  - xdebugver[31:28] = 4 and prv[1:0] = 3, both RO.
  - cause[8:6] writable only from the excp port.
  - ebreakm[15], stopcount[10], step[2] writable from both ports.
  - All other dcsr bits read 0.
- Dual write:
  - Both ports are applied in the same cycle if their addresses differ.
  - On an address match, the excp write wins and the ex write is dropped.
- Counters:
  - mcycle increments every cycle, except when debug_mode_i & dcsr.stopcount.
  - minstret increments when inst_retired_i, except when debug_mode_i & dcsr.stopcount.
  - Both are 64-bit and wrap 2^64-1 -> 0.
  - A write to the low or high half replaces that half; the whole counter does not increment that cycle.
  - A carry from the low half into the high half is normal increment behaviour.

## Timing
- All writes take effect on the next rising clk.
- Reads and *_o outputs reflect the registered value, with no write bypass: a read in the same cycle as a write returns the old value.
- ex_rdata_o is combinational from ex_raddr_i.
- Reset values:
  - mstatus 0x0000_1800
  - dcsr 0x4000_0003
  - all other R/W registers and counters 0
  - ex_rdata_o follows ex_raddr_i even while in reset
- Reset mid-operation: all state returns to the reset values asynchronously; the next write after reset is applied normally.

## Structure
- CSR address constants use the existing CSR_* defines in defines.sv.
- New entries to add there: CSR_MIP, CSR_MHARTID, CSR_DSCRATCH0, CSR_MINSTRET(H), CSR_INSTRET(H), CSR_CYCLE(H).
- Write-mask constants (MSTATUS_WMASK, MIE_WMASK, DCSR_EX_WMASK, DCSR_EXCP_WMASK) are defined alongside them.
- Sub-module csr_counter64 (inputs: inc, we_lo, we_hi, wdata; output: 64-bit value) is instantiated for mcycle and for minstret.

## Test plan
- Reset, then read 0x300, 0x7B0, 0x301 -> 0x0000_1800, 0x4000_0003, 0x4000_0100.
- ex write 0xFFFF_FFFF to 0x300 -> mstatus_o = 0x0000_1888; write 0xFFFF_FFFF to 0x305 -> mtvec_o = 0xFFFF_FFFC.
- Same-cycle excp write 0x8000_000B and ex write 0x5 to 0x342 -> mcause reads 0x8000_000B. Different addresses (excp 0x342, ex 0x340) -> both updated.
- ex write 0xFFFF_FFFF to 0xB00, then idle 2 cycles -> mcycle = 0x0000_0001_0000_0001 (wrap carries into mcycleh). With debug_mode_i=1 and stopcount=1 -> mcycle frozen.
- irq_timer_i=1, read 0x344 -> 0x80; ex write to 0x344 -> no change.
- ex write 0xFFFF_FFFF to 0x7B0 -> dcsr = 0x4000_8407 (cause bits unchanged); excp write with cause 3'h3 -> dcsr[8:6] = 3.
